// File: rtl/bf_pc_sequencer.sv
// Program counter and loop controller for the Brainfuck core.
// Drives the ROM address, qualifies which opcodes the datapath executes,
// resolves '[' / ']' with a return-address stack and a forward bracket
// scanner, halts at program end and traps bracket/stack faults.
//
// Handshake: step_en is a one-cycle strobe with no back-pressure. In RUN an
// instruction slot is consumed on every rising edge where step_en is high;
// exec_valid marks the slots where the datapath must apply opecode.
module bf_pc_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 16,
   parameter int SCAN_W      = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             step_en,
   input  logic [2:0]                       opecode,
   input  logic                             rom_overrun,
   input  logic                             cell_zero,
   output logic [ADDR_W-1:0]                rom_addr,
   output logic                             exec_valid,
   output logic                             scanning,
   output logic [$clog2(STACK_DEPTH):0]     loop_level,
   output logic                             halted,
   output logic                             error,
   output logic [1:0]                       err_code
);

   localparam int SP_W = $clog2(STACK_DEPTH) + 1;

   localparam logic [2:0] OP_OPEN  = 3'd6;
   localparam logic [2:0] OP_CLOSE = 3'd7;

   localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
   localparam logic [1:0] ERR_UNMATCHED = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_SCAN = 2'd1,
      ST_HALT = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [SP_W-1:0]     sp;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

   logic [ADDR_W-1:0]   pc_inc;
   logic                pc_max;
   logic                stack_full;
   logic                stack_empty;
   logic [SP_W-1:0]     sp_m1;
   logic [SP_W-2:0]     push_idx;
   logic [SP_W-2:0]     top_idx;
   logic                scan_full;

   assign pc_inc      = pc + 1'b1;
   assign pc_max      = &pc;
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign sp_m1       = sp - 1'b1;
   assign push_idx    = sp[SP_W-2:0];
   assign top_idx     = sp_m1[SP_W-2:0];
   assign scan_full   = &scan_cnt;

   // Datapath opcodes are only honoured in a live RUN slot inside the program
   assign exec_valid = (state == ST_RUN) & step_en & ~rom_overrun & (opecode < OP_OPEN);

   assign rom_addr   = pc;
   assign loop_level = sp;
   assign scanning   = (state == ST_SCAN);

   // Sequencer FSM: PC, return stack, scan depth and sticky status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         pc       <= '0;
         sp       <= '0;
         scan_cnt <= '0;
         halted   <= 1'b0;
         error    <= 1'b0;
         err_code <= 2'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (step_en) begin
                  if (rom_overrun) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else if (opecode < OP_OPEN) begin
                     // The PC never wraps: stepping off the top ends the program
                     if (pc_max) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end else begin
                        pc <= pc_inc;
                     end
                  end else if (opecode == OP_OPEN) begin
                     if (cell_zero) begin
                        if (pc_max) begin
                           state  <= ST_HALT;
                           halted <= 1'b1;
                        end else begin
                           scan_cnt <= SCAN_W'(1);
                           pc       <= pc_inc;
                           state    <= ST_SCAN;
                        end
                     end else if (stack_full) begin
                        state    <= ST_ERR;
                        error    <= 1'b1;
                        err_code <= ERR_OVERFLOW;
                     end else if (pc_max) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end else begin
                        stack_mem[push_idx] <= pc;
                        sp                  <= sp + 1'b1;
                        pc                  <= pc_inc;
                     end
                  end else begin
                     // ']': loop back keeps the entry on the stack, exit pops it
                     if (stack_empty) begin
                        state    <= ST_ERR;
                        error    <= 1'b1;
                        err_code <= ERR_UNDERFLOW;
                     end else if (!cell_zero) begin
                        pc <= stack_mem[top_idx] + 1'b1;
                     end else if (pc_max) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end else begin
                        sp <= sp_m1;
                        pc <= pc_inc;
                     end
                  end
               end
            end
            ST_SCAN: begin
               // Scanning ignores step_en; running off the program or the
               // address space means the '[' has no partner
               if (rom_overrun || pc_max) begin
                  state    <= ST_ERR;
                  error    <= 1'b1;
                  err_code <= ERR_UNMATCHED;
               end else if (opecode == OP_OPEN) begin
                  if (scan_full) begin
                     state    <= ST_ERR;
                     error    <= 1'b1;
                     err_code <= ERR_UNMATCHED;
                  end else begin
                     scan_cnt <= scan_cnt + 1'b1;
                     pc       <= pc_inc;
                  end
               end else if (opecode == OP_CLOSE) begin
                  if (scan_cnt == SCAN_W'(1)) begin
                     state <= ST_RUN;
                  end
                  scan_cnt <= scan_cnt - 1'b1;
                  pc       <= pc_inc;
               end else begin
                  pc <= pc_inc;
               end
            end
            default: begin
               // HALT and ERR are terminal until reset
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf_pc_sequencer.sv
// Bench for bf_pc_sequencer: small ROM model, per-cycle vector tables with
// hand-computed expectations, plus hand-written reset sequences.
module tb_bf_pc_sequencer;

   localparam int ADDR_W      = 4;
   localparam int STACK_DEPTH = 4;
   localparam int SCAN_W      = 2;
   localparam int LVL_W       = $clog2(STACK_DEPTH) + 1;
   localparam int ROM_SIZE    = 1 << ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                step_en   = 1'b0;
   logic                cell_zero = 1'b0;
   logic [2:0]          opecode;
   logic                rom_overrun;
   logic [ADDR_W-1:0]   rom_addr;
   logic                exec_valid;
   logic                scanning;
   logic [LVL_W-1:0]    loop_level;
   logic                halted;
   logic                error;
   logic [1:0]          err_code;

   bf_pc_sequencer #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH),
      .SCAN_W      (SCAN_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .step_en     (step_en),
      .opecode     (opecode),
      .rom_overrun (rom_overrun),
      .cell_zero   (cell_zero),
      .rom_addr    (rom_addr),
      .exec_valid  (exec_valid),
      .scanning    (scanning),
      .loop_level  (loop_level),
      .halted      (halted),
      .error       (error),
      .err_code    (err_code)
   );

   // ---------------- ROM model ----------------
   logic [2:0] prog_mem [ROM_SIZE];
   int         prog_len = 0;

   always_comb begin
      rom_overrun = (int'(rom_addr) >= prog_len);
      opecode     = rom_overrun ? 3'd0 : prog_mem[rom_addr];
   end

   task automatic load_prog(input string s);
      for (int i = 0; i < ROM_SIZE; i++) prog_mem[i] = 3'd0;
      prog_len = s.len();
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            ">":     prog_mem[i] = 3'd0;
            "<":     prog_mem[i] = 3'd1;
            "+":     prog_mem[i] = 3'd2;
            "-":     prog_mem[i] = 3'd3;
            ".":     prog_mem[i] = 3'd4;
            ",":     prog_mem[i] = 3'd5;
            "[":     prog_mem[i] = 3'd6;
            default: prog_mem[i] = 3'd7;
         endcase
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic              step_en;
      logic              cell_zero;
      logic [ADDR_W-1:0] addr;
      logic              ev;
      logic              sc;
      logic [LVL_W-1:0]  lvl;
      logic              h;
      logic              e;
      logic [1:0]        code;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic se, input logic cz, input int addr, input logic ev,
                      input logic sc, input int lvl, input logic h, input logic e,
                      input int code);
      vec_t v;
      v.step_en   = se;
      v.cell_zero = cz;
      v.addr      = ADDR_W'(addr);
      v.ev        = ev;
      v.sc        = sc;
      v.lvl       = LVL_W'(lvl);
      v.h         = h;
      v.e         = e;
      v.code      = 2'(code);
      vecs.push_back(v);
   endtask

   task automatic check_out(input string name, input int idx, input vec_t v);
      checks++;
      if ({rom_addr, exec_valid, scanning, loop_level, halted, error, err_code} !==
          {v.addr, v.ev, v.sc, v.lvl, v.h, v.e, v.code}) begin
         errors++;
         $display("FAIL %s[%0d]: got addr=%0d ev=%b scan=%b lvl=%0d halt=%b err=%b code=%0d, want addr=%0d ev=%b scan=%b lvl=%0d halt=%b err=%b code=%0d",
                  name, idx, rom_addr, exec_valid, scanning, loop_level, halted, error,
                  err_code, v.addr, v.ev, v.sc, v.lvl, v.h, v.e, v.code);
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change at negedge; outputs sampled 1 time unit later, before the next posedge
   task automatic run_vecs(input string name);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         step_en   = vecs[i].step_en;
         cell_zero = vecs[i].cell_zero;
         #1;
         check_out(name, i, vecs[i]);
      end
      vecs.delete();
   endtask

   task automatic reset_dut();
      vec_t z;
      @(negedge clk);
      rst     = 1'b1;
      step_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      z = '{step_en: 1'b0, cell_zero: 1'b0, addr: '0, ev: 1'b0, sc: 1'b0,
            lvl: '0, h: 1'b0, e: 1'b0, code: 2'd0};
      check_out("reset", 0, z);
   endtask

   // ---------------- tests ----------------
   initial begin
      vec_t z;
      z = '{step_en: 1'b0, cell_zero: 1'b0, addr: '0, ev: 1'b0, sc: 1'b0,
            lvl: '0, h: 1'b0, e: 1'b0, code: 2'd0};

      // T1: "+++." runs to overrun and halts
      load_prog("+++.");
      reset_dut();
      add(1, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 0, 2, 1, 0, 0, 0, 0, 0);
      add(1, 0, 3, 1, 0, 0, 0, 0, 0);
      add(1, 0, 4, 0, 0, 0, 0, 0, 0);
      add(1, 0, 4, 0, 0, 0, 1, 0, 0);
      add(1, 0, 4, 0, 0, 0, 1, 0, 0);
      run_vecs("t1_run");

      // T6a: reset out of HALT, then step_en=0 must hold
      reset_dut();
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 1, 0, 0, 0, 0, 0);
      run_vecs("t6_hold");

      // T2: "[+]" skipped by the forward scan
      load_prog("[+]");
      reset_dut();
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 2, 0, 1, 0, 0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 1, 0, 0);
      run_vecs("t2_skip");

      // T3: "+[-]" loops three times then exits
      load_prog("+[-]");
      reset_dut();
      add(1, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 2, 1, 0, 1, 0, 0, 0);
      add(1, 0, 3, 0, 0, 1, 0, 0, 0);
      add(1, 0, 2, 1, 0, 1, 0, 0, 0);
      add(1, 0, 3, 0, 0, 1, 0, 0, 0);
      add(1, 0, 2, 1, 0, 1, 0, 0, 0);
      add(1, 0, 3, 0, 0, 1, 0, 0, 0);
      add(1, 1, 2, 1, 0, 1, 0, 0, 0);
      add(1, 1, 3, 0, 0, 1, 0, 0, 0);
      add(1, 1, 4, 0, 0, 0, 0, 0, 0);
      add(1, 1, 4, 0, 0, 0, 1, 0, 0);
      run_vecs("t3_loop");

      // T4a: five nested '[' overflow a 4-deep stack
      load_prog("[[[[[");
      reset_dut();
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 1, 0, 0, 0);
      add(1, 0, 2, 0, 0, 2, 0, 0, 0);
      add(1, 0, 3, 0, 0, 3, 0, 0, 0);
      add(1, 0, 4, 0, 0, 4, 0, 0, 0);
      add(1, 0, 4, 0, 0, 4, 0, 1, 1);
      add(1, 1, 4, 0, 0, 4, 0, 1, 1);
      run_vecs("t4_overflow");

      // T4b: ']' with empty stack
      load_prog("]");
      reset_dut();
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 1, 2);
      add(1, 1, 0, 0, 0, 0, 0, 1, 2);
      run_vecs("t4_underflow");

      // T5: "[[]" scan runs off the program
      load_prog("[[]");
      reset_dut();
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 1, 2, 0, 1, 0, 0, 0, 0);
      add(1, 1, 3, 0, 1, 0, 0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 0, 1, 3);
      run_vecs("t5_unmatched");

      // Scan nesting counter saturates (SCAN_W=2: all-ones is 3)
      load_prog("[[[[]]]]");
      reset_dut();
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 1, 2, 0, 1, 0, 0, 0, 0);
      add(1, 1, 3, 0, 1, 0, 0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 0, 1, 3);
      run_vecs("scan_overflow");

      // PC at the top of the address space halts instead of wrapping
      load_prog("++++++++++++++++");
      reset_dut();
      for (int i = 0; i < ROM_SIZE; i++) add(1, 0, i, 1, 0, 0, 0, 0, 0);
      add(1, 0, ROM_SIZE - 1, 0, 0, 0, 1, 0, 0);
      run_vecs("pc_top");

      // T6b: reset asserted mid-scan
      load_prog("[++++]");
      reset_dut();
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0, 0, 0, 0);
      run_vecs("t6_prescan");
      @(negedge clk);
      rst = 1'b1;
      #1;
      z.addr = ADDR_W'(2);
      z.sc   = 1'b1;
      check_out("t6_scan_before_rst", 0, z);
      @(negedge clk);
      rst = 1'b0;
      #1;
      z.addr = '0;
      z.sc   = 1'b0;
      z.step_en = 1'b0;
      check_out("t6_after_rst", 0, z);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
